// File: rtl/pwm_soft_start_ctrl_if.sv
// pwm_soft_start_ctrl_if
//   Control/status bundle between a PWM sequencer and whoever commands it.
//   master: drives en, fault and duty_tgt, and observes the status outputs.
//   slave : the sequencer itself.
//   Signals:
//     en           run request
//     fault        level-sensitive fault, sampled on clk
//     duty_tgt     target on-time in cycles per period (saturated to PERIOD)
//     ctrl         gate drive, straight from a flop
//     duty_cur     on-time applied in the current period
//     state        IDLE=0, RAMP=1, RUN=2, FAULT=3
//     period_start high for the cycle where the period counter is 0
interface pwm_soft_start_ctrl_if #(parameter int N = 8);
    logic         en;
    logic         fault;
    logic [N-1:0] duty_tgt;
    logic         ctrl;
    logic [N-1:0] duty_cur;
    logic [1:0]   state;
    logic         period_start;

    modport master (
        output en, fault, duty_tgt,
        input  ctrl, duty_cur, state, period_start
    );

    modport slave (
        input  en, fault, duty_tgt,
        output ctrl, duty_cur, state, period_start
    );
endinterface

// File: rtl/pwm_soft_start_ctrl.sv
// pwm_soft_start_ctrl
//   PWM sequencer with an enable/fault state machine, per-period soft-start
//   duty ramp and shadowed duty updates applied only at period wraps.
//   Ports:
//     clk  sole clock, rising edge
//     rst  asynchronous active-high reset
//     bus  pwm_soft_start_ctrl_if.slave (en, fault, duty_tgt in;
//          ctrl, duty_cur, state, period_start out)
//   Parameters:
//     N      counter / duty width
//     PERIOD cycles per switching period (2..2^N-1)
//     STEP   duty increment per period during soft start (1..PERIOD)
module pwm_soft_start_ctrl #(
    parameter int N      = 8,
    parameter int PERIOD = 200,
    parameter int STEP   = 4
) (
    input logic                 clk,
    input logic                 rst,
    pwm_soft_start_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RAMP  = 2'd1,
        S_RUN   = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam logic [N-1:0] P_LAST = N'(PERIOD - 1);
    localparam logic [N-1:0] P_FULL = N'(PERIOD);
    localparam logic [N-1:0] STEP_N = N'(STEP);
    localparam logic [N:0]   STEP_W = (N+1)'(STEP);

    state_t       state_q, state_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic [N-1:0] duty_q, duty_d;
    logic         ctrl_q;
    logic         pstart_q;

    logic [N-1:0] tgt_sat;
    logic [N-1:0] step_min;
    logic [N:0]   ramp_sum;
    logic [N-1:0] ramp_nxt;
    logic         wrap;
    logic         active_d;

    assign tgt_sat  = (bus.duty_tgt > P_FULL) ? P_FULL : bus.duty_tgt;
    assign step_min = (STEP_N < tgt_sat) ? STEP_N : tgt_sat;
    // One extra bit so duty + STEP cannot wrap before the clamp.
    assign ramp_sum = {1'b0, duty_q} + STEP_W;
    assign ramp_nxt = (ramp_sum > {1'b0, tgt_sat}) ? tgt_sat : ramp_sum[N-1:0];
    assign wrap     = (cnt_q == P_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        duty_d  = duty_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                duty_d = '0;
                if (bus.fault) begin
                    state_d = S_FAULT;
                end else if (bus.en) begin
                    // Soft start always begins at one step; reaching RUN
                    // waits for the first wrap even if the target is tiny.
                    state_d = S_RAMP;
                    duty_d  = step_min;
                end
            end
            S_RAMP, S_RUN: begin
                if (bus.fault) begin
                    state_d = S_FAULT;
                    cnt_d   = '0;
                    duty_d  = '0;
                end else if (!bus.en) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    duty_d  = '0;
                end else if (wrap) begin
                    cnt_d = '0;
                    if (state_q == S_RAMP) begin
                        // A target lowered below duty_cur clamps here too.
                        duty_d = ramp_nxt;
                        if (ramp_nxt == tgt_sat) state_d = S_RUN;
                    end else begin
                        duty_d = tgt_sat;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FAULT: begin
                cnt_d  = '0;
                duty_d = '0;
                if (!bus.en && !bus.fault) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign active_d = (state_d == S_RAMP) || (state_d == S_RUN);

    // Outputs are loaded from next-state values so ctrl tracks
    // (active && cnt < duty_cur) in the same cycle, without lag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            duty_q   <= '0;
            ctrl_q   <= 1'b0;
            pstart_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            duty_q   <= duty_d;
            ctrl_q   <= active_d && (cnt_d < duty_d);
            pstart_q <= active_d && (cnt_d == '0);
        end
    end

    assign bus.ctrl         = ctrl_q;
    assign bus.duty_cur     = duty_q;
    assign bus.state        = state_q;
    assign bus.period_start = pstart_q;

endmodule

// File: tb/tb_pwm_soft_start_ctrl.sv
module tb_pwm_soft_start_ctrl;
    localparam int N      = 8;
    localparam int PERIOD = 10;
    localparam int STEP   = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   hi, ps;

    pwm_soft_start_ctrl_if #(.N(N)) bus ();

    pwm_soft_start_ctrl #(.N(N), .PERIOD(PERIOD), .STEP(STEP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int c, input int d, input int s);
        chk({tag, ".ctrl"},  32'(bus.ctrl), 32'(c));
        chk({tag, ".duty"},  32'(bus.duty_cur), 32'(d));
        chk({tag, ".state"}, 32'(bus.state), 32'(s));
    endtask

    // Samples one full period starting at cnt==0; optionally changes the
    // target right after the sample at index chg_at.
    task automatic run_period(input int chg_at, input logic [N-1:0] new_tgt,
                              output int h, output int p);
        h = 0;
        p = 0;
        for (int i = 0; i < PERIOD; i++) begin
            h += int'(bus.ctrl);
            p += int'(bus.period_start);
            if (i == chg_at) bus.duty_tgt = new_tgt;
            tick();
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.fault    = 1'b0;
        bus.duty_tgt = '0;
        tick();
        tick();
        chk_out("reset", 0, 0, 0);
        chk("reset.pstart", 32'(bus.period_start), 0);
        rst = 1'b0;
        tick();
        chk_out("idle", 0, 0, 0);

        // 1. soft start 4 -> 8 -> 10
        bus.duty_tgt = 8'd10;
        bus.en       = 1'b1;
        tick();
        chk_out("ss.p1", 1, 4, 1);
        chk("ss.p1.pstart", 32'(bus.period_start), 1);
        run_period(-1, 8'd0, hi, ps);
        chk("ss.p1.hi", 32'(hi), 4);
        chk("ss.p1.ps", 32'(ps), 1);
        chk_out("ss.p2", 1, 8, 1);
        run_period(-1, 8'd0, hi, ps);
        chk("ss.p2.hi", 32'(hi), 8);
        chk_out("ss.p3", 1, 10, 2);
        run_period(-1, 8'd0, hi, ps);
        chk("ss.p3.hi", 32'(hi), 10);

        // 2. shadowed updates
        bus.duty_tgt = 8'd3;
        run_period(-1, 8'd0, hi, ps);
        chk("sh.keep10.hi", 32'(hi), 10);
        chk_out("sh.d3", 1, 3, 2);
        run_period(5, 8'd7, hi, ps);
        chk("sh.mid.hi", 32'(hi), 3);
        chk("sh.mid.ps", 32'(ps), 1);
        chk_out("sh.d7", 1, 7, 2);
        run_period(-1, 8'd0, hi, ps);
        chk("sh.d7.hi", 32'(hi), 7);
        chk("sh.d7.ps", 32'(ps), 1);

        // 3. fault pulse
        tick();
        tick();
        chk("flt.pre.ctrl", 32'(bus.ctrl), 1);
        bus.fault = 1'b1;
        tick();
        bus.fault = 1'b0;
        chk_out("flt.hit", 0, 0, 3);
        tick();
        tick();
        chk_out("flt.hold", 0, 0, 3);
        bus.en = 1'b0;
        tick();
        chk_out("flt.idle", 0, 0, 0);
        bus.en = 1'b1;
        tick();
        chk_out("flt.restart", 1, 4, 1);

        // 4a. saturated target
        bus.duty_tgt = 8'd250;
        run_period(-1, 8'd0, hi, ps);
        chk("sat.p1.hi", 32'(hi), 4);
        chk_out("sat.p2", 1, 8, 1);
        run_period(-1, 8'd0, hi, ps);
        chk_out("sat.run", 1, 10, 2);
        run_period(-1, 8'd0, hi, ps);
        chk("sat.run.hi", 32'(hi), 10);
        chk("sat.wrap.ctrl", 32'(bus.ctrl), 1);

        // 4b. zero target
        bus.en = 1'b0;
        tick();
        chk_out("zero.idle", 0, 0, 0);
        bus.duty_tgt = 8'd0;
        bus.en       = 1'b1;
        tick();
        chk_out("zero.ramp", 0, 0, 1);
        run_period(-1, 8'd0, hi, ps);
        chk("zero.p1.hi", 32'(hi), 0);
        chk("zero.p1.ps", 32'(ps), 1);
        chk_out("zero.run", 0, 0, 2);
        run_period(-1, 8'd0, hi, ps);
        chk("zero.p2.hi", 32'(hi), 0);

        // 5. disable mid-ramp
        bus.en = 1'b0;
        tick();
        bus.duty_tgt = 8'd10;
        bus.en       = 1'b1;
        tick();
        run_period(-1, 8'd0, hi, ps);
        chk_out("dis.p2", 1, 8, 1);
        tick();
        tick();
        chk("dis.cnt2.ctrl", 32'(bus.ctrl), 1);
        bus.en = 1'b0;
        tick();
        chk_out("dis.off", 0, 0, 0);

        // 6. async reset mid-RUN
        bus.en = 1'b1;
        tick();
        run_period(-1, 8'd0, hi, ps);
        run_period(-1, 8'd0, hi, ps);
        chk_out("ar.run", 1, 10, 2);
        tick();
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk_out("ar.async", 0, 0, 0);
        chk("ar.async.pstart", 32'(bus.period_start), 0);
        tick();
        tick();
        chk_out("ar.hold", 0, 0, 0);
        rst = 1'b0;
        tick();
        chk_out("ar.rel", 1, 4, 1);
        run_period(-1, 8'd0, hi, ps);
        chk("ar.rel.hi", 32'(hi), 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
